// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer
//
// Owns the architectural PC and runs the instruction fetch loop. Each fetch
// sends the PC to instruction memory with a req/ack handshake. The returned
// word is held in a one-entry buffer and offered to decode with valid/ready.
// Only one fetch is ever outstanding, and there is no prefetch.
//
// The execute stage can redirect fetch with a one-cycle pulse. The target is
// base + imm; JALR targets also have bit 0 cleared. A misaligned target raises
// a sticky fault and parks the sequencer until reset.
//
// Ports:
//   clk               system clock, rising edge
//   rst_n             asynchronous active-low reset
//   o_imem_req        fetch request to instruction memory
//   o_imem_addr       fetch address, stable while o_imem_req is high
//   i_imem_ack        memory returns i_imem_rdata this cycle
//   i_imem_rdata      instruction word, valid with i_imem_ack
//   o_instr_valid     buffered instruction available to decode
//   o_instr           buffered instruction
//   o_instr_pc        PC of the buffered instruction
//   i_instr_ready     decode accepts the instruction (valid & ready)
//   i_redirect_valid  taken branch/jump pulse
//   i_redirect_base   PC (branch/JAL) or rs1 (JALR)
//   i_redirect_imm    sign-extended immediate
//   i_redirect_jalr   clear bit 0 of the target
//   o_fault           misaligned target seen; sticky until reset
//   o_fault_addr      offending target
//
// Only XLEN = 32 is supported.

module pc_fetch_sequencer #(
  parameter int unsigned      XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_ack,
  input  logic [31:0]     i_imem_rdata,
  output logic            o_instr_valid,
  output logic [31:0]     o_instr,
  output logic [XLEN-1:0] o_instr_pc,
  input  logic            i_instr_ready,
  input  logic            i_redirect_valid,
  input  logic [XLEN-1:0] i_redirect_base,
  input  logic [XLEN-1:0] i_redirect_imm,
  input  logic            i_redirect_jalr,
  output logic            o_fault,
  output logic [XLEN-1:0] o_fault_addr
);

  localparam logic [XLEN-1:0] PcStep = {{(XLEN-3){1'b0}}, 3'd4};

  typedef enum logic [1:0] {
    StReq,
    StWait,
    StHold,
    StFault
  } state_e;

  state_e            r_state,       w_state_next;
  logic [XLEN-1:0]   r_pc,          w_pc_next;
  logic [XLEN-1:0]   r_fetch_addr,  w_fetch_addr_next;
  logic              r_kill,        w_kill_next;
  logic              r_instr_valid, w_instr_valid_next;
  logic [31:0]       r_instr,       w_instr_next;
  logic [XLEN-1:0]   r_instr_pc,    w_instr_pc_next;
  logic              r_fault,       w_fault_next;
  logic [XLEN-1:0]   r_fault_addr,  w_fault_addr_next;

  logic [XLEN-1:0]   w_sum;
  logic [XLEN-1:0]   w_target;
  logic              w_misaligned;

  // Redirect target, wrapping mod 2^XLEN. JALR drops bit 0 only, so a JALR
  // target with bit 1 set is still reported as misaligned.
  always_comb begin
    w_sum        = i_redirect_base + i_redirect_imm;
    w_target     = {w_sum[XLEN-1:1], w_sum[0] & ~i_redirect_jalr};
    w_misaligned = (w_target[1:0] != 2'b00);
  end

  // Next-state logic. A redirect beats ack and ready in every live state.
  always_comb begin
    w_state_next       = r_state;
    w_pc_next          = r_pc;
    w_fetch_addr_next  = r_fetch_addr;
    w_kill_next        = r_kill;
    w_instr_valid_next = r_instr_valid;
    w_instr_next       = r_instr;
    w_instr_pc_next    = r_instr_pc;
    w_fault_next       = r_fault;
    w_fault_addr_next  = r_fault_addr;

    if (r_state != StFault && i_redirect_valid) begin
      // Flush the buffer even if decode is taking it this same cycle.
      w_instr_valid_next = 1'b0;
      if (w_misaligned) begin
        w_fault_next      = 1'b1;
        w_fault_addr_next = w_target;
        w_kill_next       = 1'b0;
        w_state_next      = StFault;
      end else begin
        w_pc_next = w_target;
        if (r_state == StWait && !i_imem_ack) begin
          // The old request is still open. Keep its address on the bus and
          // drop its data when the ack finally arrives.
          w_kill_next = 1'b1;
        end else begin
          w_kill_next       = 1'b0;
          w_fetch_addr_next = w_target;
          w_state_next      = StReq;
        end
      end
    end else begin
      unique case (r_state)
        StReq: begin
          w_state_next = StWait;
        end
        StWait: begin
          if (i_imem_ack) begin
            if (r_kill) begin
              w_kill_next       = 1'b0;
              w_fetch_addr_next = r_pc;
              w_state_next      = StReq;
            end else begin
              w_instr_next       = i_imem_rdata;
              w_instr_pc_next    = r_pc;
              w_instr_valid_next = 1'b1;
              w_pc_next          = r_pc + PcStep;
              w_fetch_addr_next  = r_pc + PcStep;
              w_state_next       = StHold;
            end
          end
        end
        StHold: begin
          if (i_instr_ready) begin
            w_instr_valid_next = 1'b0;
            w_fetch_addr_next  = r_pc;
            w_state_next       = StReq;
          end
        end
        StFault: begin
          w_instr_valid_next = 1'b0;
        end
        default: begin
          w_state_next = StFault;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= StReq;
      r_pc          <= RESET_PC;
      r_fetch_addr  <= RESET_PC;
      r_kill        <= 1'b0;
      r_instr_valid <= 1'b0;
      r_instr       <= '0;
      r_instr_pc    <= '0;
      r_fault       <= 1'b0;
      r_fault_addr  <= '0;
    end else begin
      r_state       <= w_state_next;
      r_pc          <= w_pc_next;
      r_fetch_addr  <= w_fetch_addr_next;
      r_kill        <= w_kill_next;
      r_instr_valid <= w_instr_valid_next;
      r_instr       <= w_instr_next;
      r_instr_pc    <= w_instr_pc_next;
      r_fault       <= w_fault_next;
      r_fault_addr  <= w_fault_addr_next;
    end
  end

  // The reset state is REQ, but the request must stay low while reset is
  // asserted. It is therefore gated by rst_n so it drops the moment reset hits.
  always_comb begin
    o_imem_req    = rst_n & ((r_state == StReq) || (r_state == StWait));
    o_imem_addr   = r_fetch_addr;
    o_instr_valid = r_instr_valid;
    o_instr       = r_instr;
    o_instr_pc    = r_instr_pc;
    o_fault       = r_fault;
    o_fault_addr  = r_fault_addr;
  end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Testbench for pc_fetch_sequencer. A small memory responder answers fetches.
// Expected {instr, pc} pairs are queued when data is returned and compared
// when decode takes the buffered instruction.

module tb_pc_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_ack;
  logic [31:0] i_imem_rdata;
  logic        o_instr_valid;
  logic [31:0] o_instr;
  logic [31:0] o_instr_pc;
  logic        i_instr_ready;
  logic        i_redirect_valid;
  logic [31:0] i_redirect_base;
  logic [31:0] i_redirect_imm;
  logic        i_redirect_jalr;
  logic        o_fault;
  logic [31:0] o_fault_addr;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] sb_q[$];

  pc_fetch_sequencer #(
    .XLEN     (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .o_imem_req       (o_imem_req),
    .o_imem_addr      (o_imem_addr),
    .i_imem_ack       (i_imem_ack),
    .i_imem_rdata     (i_imem_rdata),
    .o_instr_valid    (o_instr_valid),
    .o_instr          (o_instr),
    .o_instr_pc       (o_instr_pc),
    .i_instr_ready    (i_instr_ready),
    .i_redirect_valid (i_redirect_valid),
    .i_redirect_base  (i_redirect_base),
    .i_redirect_imm   (i_redirect_imm),
    .i_redirect_jalr  (i_redirect_jalr),
    .o_fault          (o_fault),
    .o_fault_addr     (o_fault_addr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] calc_target(input logic [31:0] b, input logic [31:0] i,
                                              input logic j);
    logic [31:0] t;
    t = b + i;
    if (j) t[0] = 1'b0;
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_imem_ack       = 1'b0;
    i_imem_rdata     = '0;
    i_redirect_valid = 1'b0;
    i_redirect_base  = '0;
    i_redirect_imm   = '0;
    i_redirect_jalr  = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    idle_inputs();
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drive_redirect(input logic [31:0] b, input logic [31:0] i, input logic j);
    i_redirect_valid = 1'b1;
    i_redirect_base  = b;
    i_redirect_imm   = i;
    i_redirect_jalr  = j;
  endtask

  // Memory responder. It waits (bounded) for a request, then acks after `lat`
  // cycles. Use lat >= 1 if the request may still be in its REQ cycle.
  task automatic serve(input int lat, input bit keep, output logic [31:0] addr,
                       output logic ok);
    ok   = 1'b0;
    addr = 'x;
    for (int i = 0; i < 20 && o_imem_req !== 1'b1; i++) tick();
    if (o_imem_req !== 1'b1) return;
    addr = o_imem_addr;
    repeat (lat) tick();
    i_imem_ack   = 1'b1;
    i_imem_rdata = mem_word(addr);
    if (keep) sb_q.push_back({mem_word(addr), addr});
    tick();
    i_imem_ack = 1'b0;
    ok = 1'b1;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    i_instr_ready = 1'b1;
    idle_inputs();
    #2;
    n_checks++; if (o_imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", o_imem_req); end
    n_checks++; if (o_instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", o_instr_valid); end
    n_checks++; if (o_instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h want 0", o_instr); end
    n_checks++; if (o_instr_pc !== 32'h0) begin n_fail++; $display("FAIL reset_instr_pc: got %h want 0", o_instr_pc); end
    n_checks++; if (o_fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault: got %b want 0", o_fault); end
    n_checks++; if (o_fault_addr !== 32'h0) begin n_fail++; $display("FAIL reset_fault_addr: got %h want 0", o_fault_addr); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    n_checks++; if (o_imem_req !== 1'b1) begin n_fail++; $display("FAIL post_reset_req: got %b want 1", o_imem_req); end
    n_checks++; if (o_imem_addr !== 32'h0) begin n_fail++; $display("FAIL post_reset_addr: got %h want 0", o_imem_addr); end
  endtask

  task automatic test_seq_fetch();
    logic [31:0] a;
    logic        ok;
    logic [63:0] e;
    i_instr_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      serve(1, 1'b1, a, ok);
      n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL seq_req_seen[%0d]: got %b want 1", k, ok); end
      n_checks++; if (a !== 32'(4 * k)) begin n_fail++; $display("FAIL seq_addr[%0d]: got %h want %h", k, a, 32'(4 * k)); end
      n_checks++; if (o_instr_valid !== 1'b1) begin n_fail++; $display("FAIL seq_valid[%0d]: got %b want 1", k, o_instr_valid); end
      e = (sb_q.size() > 0) ? sb_q.pop_front() : 64'hx;
      n_checks++; if ({o_instr, o_instr_pc} !== e) begin n_fail++; $display("FAIL seq_data[%0d]: got %h want %h", k, {o_instr, o_instr_pc}, e); end
      tick();
      n_checks++; if (o_instr_valid !== 1'b0) begin n_fail++; $display("FAIL seq_transfer[%0d]: got valid %b want 0", k, o_instr_valid); end
    end
  endtask

  task automatic test_stall();
    logic [31:0] a;
    logic        ok;
    logic [63:0] e;
    i_instr_ready = 1'b0;
    serve(1, 1'b1, a, ok);
    n_checks++; if (ok !== 1'b1 || a !== 32'h0000_000C) begin n_fail++; $display("FAIL stall_fetch: got ok %b addr %h want ok 1 addr c", ok, a); end
    e = (sb_q.size() > 0) ? sb_q[0] : 64'hx;
    for (int c = 0; c < 5; c++) begin
      n_checks++; if (o_instr_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid[%0d]: got %b want 1", c, o_instr_valid); end
      n_checks++; if ({o_instr, o_instr_pc} !== e) begin n_fail++; $display("FAIL stall_data[%0d]: got %h want %h", c, {o_instr, o_instr_pc}, e); end
      n_checks++; if (o_imem_req !== 1'b0) begin n_fail++; $display("FAIL stall_req[%0d]: got %b want 0", c, o_imem_req); end
      tick();
    end
    i_instr_ready = 1'b1;
    e = (sb_q.size() > 0) ? sb_q.pop_front() : 64'hx;
    n_checks++; if (o_instr_valid !== 1'b1 || {o_instr, o_instr_pc} !== e) begin n_fail++; $display("FAIL stall_release: got valid %b data %h want valid 1 data %h", o_instr_valid, {o_instr, o_instr_pc}, e); end
    tick();
    n_checks++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h0000_0010) begin n_fail++; $display("FAIL stall_next_req: got req %b addr %h want req 1 addr 10", o_imem_req, o_imem_addr); end
  endtask

  task automatic test_redirect_hold();
    logic [31:0] a;
    logic [31:0] tgt;
    logic        ok;
    logic [63:0] e;
    i_instr_ready = 1'b0;
    serve(1, 1'b0, a, ok);
    n_checks++; if (ok !== 1'b1 || o_instr_valid !== 1'b1) begin n_fail++; $display("FAIL rdh_hold: got ok %b valid %b want 1 1", ok, o_instr_valid); end
    tgt = calc_target(32'h0000_0100, 32'hFFFF_FFF0, 1'b0);
    drive_redirect(32'h0000_0100, 32'hFFFF_FFF0, 1'b0);
    i_instr_ready = 1'b1;
    tick();
    i_redirect_valid = 1'b0;
    n_checks++; if (o_instr_valid !== 1'b0) begin n_fail++; $display("FAIL rdh_flush: got valid %b want 0", o_instr_valid); end
    n_checks++; if (o_imem_req !== 1'b1 || o_imem_addr !== tgt) begin n_fail++; $display("FAIL rdh_req: got req %b addr %h want req 1 addr %h", o_imem_req, o_imem_addr, tgt); end
    serve(1, 1'b1, a, ok);
    n_checks++; if (ok !== 1'b1 || a !== 32'h0000_00F0) begin n_fail++; $display("FAIL rdh_fetch_addr: got ok %b addr %h want ok 1 addr f0", ok, a); end
    e = (sb_q.size() > 0) ? sb_q.pop_front() : 64'hx;
    n_checks++; if ({o_instr, o_instr_pc} !== e) begin n_fail++; $display("FAIL rdh_data: got %h want %h", {o_instr, o_instr_pc}, e); end
    tick();
  endtask

  task automatic test_redirect_wait();
    logic [31:0] a;
    logic        ok;
    logic [63:0] e;
    i_instr_ready = 1'b1;
    n_checks++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h0000_00F4) begin n_fail++; $display("FAIL rdw_start: got req %b addr %h want req 1 addr f4", o_imem_req, o_imem_addr); end
    tick();
    drive_redirect(32'h0000_0200, 32'h0000_0040, 1'b0);
    tick();
    i_redirect_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      n_checks++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h0000_00F4) begin n_fail++; $display("FAIL rdw_addr_stable[%0d]: got req %b addr %h want req 1 addr f4", c, o_imem_req, o_imem_addr); end
      n_checks++; if (o_instr_valid !== 1'b0) begin n_fail++; $display("FAIL rdw_valid[%0d]: got %b want 0", c, o_instr_valid); end
      tick();
    end
    i_imem_ack   = 1'b1;
    i_imem_rdata = 32'hDEAD_BEEF;
    tick();
    i_imem_ack = 1'b0;
    n_checks++; if (o_instr_valid !== 1'b0) begin n_fail++; $display("FAIL rdw_dropped: got valid %b want 0", o_instr_valid); end
    n_checks++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h0000_0240) begin n_fail++; $display("FAIL rdw_new_req: got req %b addr %h want req 1 addr 240", o_imem_req, o_imem_addr); end
    serve(1, 1'b1, a, ok);
    n_checks++; if (ok !== 1'b1 || a !== 32'h0000_0240) begin n_fail++; $display("FAIL rdw_fetch: got ok %b addr %h want ok 1 addr 240", ok, a); end
    e = (sb_q.size() > 0) ? sb_q.pop_front() : 64'hx;
    n_checks++; if ({o_instr, o_instr_pc} !== e) begin n_fail++; $display("FAIL rdw_data: got %h want %h", {o_instr, o_instr_pc}, e); end
    tick();
  endtask

  task automatic test_jalr_fault();
    logic [31:0] tgt;
    tgt = calc_target(32'h0000_1001, 32'h0000_0002, 1'b1);
    drive_redirect(32'h0000_1001, 32'h0000_0002, 1'b1);
    tick();
    idle_inputs();
    n_checks++; if (o_fault !== 1'b1) begin n_fail++; $display("FAIL jalr_fault: got %b want 1", o_fault); end
    n_checks++; if (o_fault_addr !== tgt) begin n_fail++; $display("FAIL jalr_fault_addr: got %h want %h", o_fault_addr, tgt); end
    n_checks++; if (o_imem_req !== 1'b0 || o_instr_valid !== 1'b0) begin n_fail++; $display("FAIL jalr_quiet: got req %b valid %b want 0 0", o_imem_req, o_instr_valid); end
    for (int c = 0; c < 4; c++) begin
      drive_redirect(32'h0000_0400, 32'h0, 1'b0);
      i_imem_ack   = 1'b1;
      i_imem_rdata = 32'h1111_2222;
      tick();
      n_checks++; if (o_imem_req !== 1'b0 || o_instr_valid !== 1'b0) begin n_fail++; $display("FAIL fault_terminal[%0d]: got req %b valid %b want 0 0", c, o_imem_req, o_instr_valid); end
      n_checks++; if (o_fault !== 1'b1 || o_fault_addr !== tgt) begin n_fail++; $display("FAIL fault_sticky[%0d]: got %b %h want 1 %h", c, o_fault, o_fault_addr, tgt); end
    end
    idle_inputs();
  endtask

  task automatic test_wrap_and_reset();
    logic [31:0] a;
    logic        ok;
    logic [63:0] e;
    apply_reset();
    i_instr_ready = 1'b1;
    drive_redirect(32'hFFFF_FFF0, 32'h0000_000C, 1'b0);
    tick();
    i_redirect_valid = 1'b0;
    serve(1, 1'b1, a, ok);
    n_checks++; if (ok !== 1'b1 || a !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_fetch: got ok %b addr %h want ok 1 addr fffffffc", ok, a); end
    e = (sb_q.size() > 0) ? sb_q.pop_front() : 64'hx;
    n_checks++; if ({o_instr, o_instr_pc} !== e) begin n_fail++; $display("FAIL wrap_data: got %h want %h", {o_instr, o_instr_pc}, e); end
    tick();
    n_checks++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h0 || o_fault !== 1'b0) begin n_fail++; $display("FAIL wrap_next: got req %b addr %h fault %b want 1 0 0", o_imem_req, o_imem_addr, o_fault); end
    tick();
    // Now in WAIT: reset with the request outstanding and an ack arriving.
    rst_n        = 1'b0;
    i_imem_ack   = 1'b1;
    i_imem_rdata = 32'h0BAD_C0DE;
    sb_q.delete();
    #1;
    n_checks++; if (o_imem_req !== 1'b0 || o_instr_valid !== 1'b0) begin n_fail++; $display("FAIL midwait_reset_req: got req %b valid %b want 0 0", o_imem_req, o_instr_valid); end
    n_checks++; if (o_instr !== 32'h0 || o_instr_pc !== 32'h0) begin n_fail++; $display("FAIL midwait_reset_buf: got %h %h want 0 0", o_instr, o_instr_pc); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    n_checks++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h0) begin n_fail++; $display("FAIL restart_req: got req %b addr %h want 1 0", o_imem_req, o_imem_addr); end
    tick();
    i_imem_ack = 1'b0;
    n_checks++; if (o_instr_valid !== 1'b0) begin n_fail++; $display("FAIL stale_ack_ignored: got valid %b want 0", o_instr_valid); end
    serve(0, 1'b1, a, ok);
    n_checks++; if (ok !== 1'b1 || a !== 32'h0) begin n_fail++; $display("FAIL restart_fetch: got ok %b addr %h want ok 1 addr 0", ok, a); end
    e = (sb_q.size() > 0) ? sb_q.pop_front() : 64'hx;
    n_checks++; if (o_instr_valid !== 1'b1 || {o_instr, o_instr_pc} !== e) begin n_fail++; $display("FAIL restart_data: got valid %b data %h want 1 %h", o_instr_valid, {o_instr, o_instr_pc}, e); end
    tick();
  endtask

  initial begin
    test_reset();
    test_seq_fetch();
    test_stall();
    test_redirect_hold();
    test_redirect_wait();
    test_jalr_fault();
    test_wrap_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
